// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// Holds the FSM state encoding and baud divider arithmetic.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam int UART_DATA_BITS = 8;

  function automatic logic [15:0] baud_div(
    input int clk_hz,
    input int baud
  );
    int d;
    d = clk_hz / baud;
    return d[15:0];
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO queueing bytes ahead of the serializer.
// Head entry is always visible on dout; count is registered.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("uart_tx_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1/8N2 UART transmitter with write-strobe/ready input.
// Frames are sent back-to-back straight out of the FIFO.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 200_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  input  logic                      tx_start,
  output logic                      tx_ready,
  output logic                      tx_busy,
  output logic                      tx_done,
  output logic                      txd
);

  localparam int          DIV_I     = CLK_HZ / BAUD;
  localparam logic [15:0] DIV       = baud_div(CLK_HZ, BAUD);
  localparam logic [15:0] DIV_M1    = DIV - 16'd1;
  localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

  if (DIV_I < 2 || DIV_I > 65535) begin : g_div_chk
    $error("uart_tx: CLK_HZ/BAUD must be in 2..65535");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_chk
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  uart_tx_state_t            state_q, state_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [2:0]                idx_q, idx_d;
  logic                      stop_q, stop_d;
  logic                      txd_q, txd_d;
  logic                      done;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_dout;
  logic                      bit_end;

  uart_tx_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_start),
    .pop   (fifo_pop),
    .din   (tx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bit_end  = (cnt_q == 16'd0);
  assign tx_ready = ~fifo_full;
  assign tx_busy  = (state_q != IDLE);
  assign tx_done  = done & ~rst;
  assign txd      = txd_q;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    fifo_pop = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_dout;
          cnt_d    = DIV_M1;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = DIV_M1;
          idx_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = DIV_M1;
          if (idx_q == 3'd7) begin
            stop_d  = 1'b0;
            state_d = STOP;
          end else begin
            shreg_d = shreg_q >> 1;
            idx_d   = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (!bit_end) begin
          cnt_d = cnt_q - 16'd1;
        end else if (stop_q != STOP_LAST) begin
          stop_d = 1'b1;
          cnt_d  = DIV_M1;
        end else begin
          done = 1'b1;
          // chain straight into the next start bit when more is queued
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_dout;
            cnt_d    = DIV_M1;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    txd_d = 1'b1;
    if (state_d == START) txd_d = 1'b0;
    if (state_d == DATA)  txd_d = shreg_d[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with a line-decoding scoreboard.
// Two instances cover one and two stop bits at DIV=4.
module tb_uart_tx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 250_000;
  localparam int DIV    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data1 = 8'h00;
  logic [7:0] tx_data2 = 8'h00;
  logic       tx_start1 = 1'b0;
  logic       tx_start2 = 1'b0;
  logic       tx_ready1, tx_busy1, tx_done1, txd1;
  logic       tx_ready2, tx_busy2, tx_done2, txd2;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] sb[$];
  logic       rx_en = 1'b1;
  logic       rx_sel = 1'b0;
  int         rx_done_cnt = 0;
  int         rx_err_cnt = 0;
  logic       rx_line;

  always #5 clk = ~clk;

  assign rx_line = rx_sel ? txd2 : txd1;

  uart_tx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (4),
    .STOP_BITS  (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data1),
    .tx_start (tx_start1),
    .tx_ready (tx_ready1),
    .tx_busy  (tx_busy1),
    .tx_done  (tx_done1),
    .txd      (txd1)
  );

  uart_tx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (4),
    .STOP_BITS  (2)
  ) dut2 (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data2),
    .tx_start (tx_start2),
    .tx_ready (tx_ready2),
    .tx_busy  (tx_busy2),
    .tx_done  (tx_done2),
    .txd      (txd2)
  );

  // Receiver model: start detected on the first clock of the start bit,
  // then each bit sampled in the middle of its DIV-clock period.
  always begin : rx_model
    logic [7:0] b;
    logic [7:0] e;
    @(negedge clk);
    if (rx_line === 1'b0) begin
      repeat (DIV + DIV / 2 - 1) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        b[i] = rx_line;
        if (i < 7) repeat (DIV) @(negedge clk);
      end
      repeat (DIV) @(negedge clk);
      if (rx_en) begin
        tests++;
        if (rx_line !== 1'b1) begin
          fails++;
          rx_err_cnt++;
          $display("FAIL rx_stop: got %b want 1", rx_line);
        end
        rx_done_cnt++;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL rx_unexpected: got %h want none", b);
        end else begin
          e = sb.pop_front();
          if (b !== e) begin
            fails++;
            $display("FAIL rx_byte: got %h want %h", b, e);
          end
        end
      end
    end
  end

  function automatic logic frame_bit(input logic [7:0] d, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d left want 0", sb.size());
      sb.delete();
    end
    n = 0;
    while ((tx_busy1 || tx_busy2) && n < 3000) begin
      tick();
      n++;
    end
    repeat (5) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if (txd1 !== 1'b1 || txd2 !== 1'b1) begin
      fails++;
      $display("FAIL reset_txd: got %b%b want 11", txd1, txd2);
    end
    tests++;
    if (tx_busy1 !== 1'b0 || tx_done1 !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy_done: got %b%b want 00", tx_busy1, tx_done1);
    end
    tests++;
    if (tx_ready1 !== 1'b1 || tx_ready2 !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b%b want 11", tx_ready1, tx_ready2);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_byte();
    int   busy_n = 0;
    int   done_n = 0;
    int   done_at = 0;
    logic e;
    tx_data1 = 8'hA5;
    tx_start1 = 1'b1;
    sb.push_back(8'hA5);
    tick();
    tx_start1 = 1'b0;
    for (int k = 1; k <= 10 * DIV; k++) begin
      tick();
      e = frame_bit(8'hA5, (k - 1) / DIV);
      tests++;
      if (txd1 !== e) begin
        fails++;
        $display("FAIL single_txd clk %0d: got %b want %b", k, txd1, e);
      end
      if (tx_busy1 === 1'b1) busy_n++;
      if (tx_done1 === 1'b1) begin
        done_n++;
        done_at = k;
      end
    end
    tick();
    tests++;
    if (busy_n != 40 || tx_busy1 !== 1'b0) begin
      fails++;
      $display("FAIL single_busy: got %0d/%b want 40/0", busy_n, tx_busy1);
    end
    tests++;
    if (done_n != 1 || done_at != 40) begin
      fails++;
      $display("FAIL single_done: got %0d@%0d want 1@40", done_n, done_at);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int   busy_n = 0;
    int   done_n = 0;
    int   falls = 0;
    logic prev = 1'b0;
    logic exp_rdy;
    for (int k = 1; k <= 6; k++) begin
      tx_data1 = 8'(k);
      tx_start1 = 1'b1;
      if (k <= 5) sb.push_back(8'(k));
      tick();
      exp_rdy = (k < 5);
      tests++;
      if (tx_ready1 !== exp_rdy) begin
        fails++;
        $display("FAIL b2b_ready edge %0d: got %b want %b", k, tx_ready1, exp_rdy);
      end
      if (tx_busy1 === 1'b1) busy_n++;
      if (tx_done1 === 1'b1) done_n++;
      if (prev && tx_busy1 !== 1'b1) falls++;
      prev = tx_busy1;
    end
    tx_start1 = 1'b0;
    for (int k = 0; k < 230; k++) begin
      tick();
      if (tx_busy1 === 1'b1) busy_n++;
      if (tx_done1 === 1'b1) done_n++;
      if (prev && tx_busy1 !== 1'b1) falls++;
      prev = tx_busy1;
    end
    tests++;
    if (busy_n != 200 || falls != 1) begin
      fails++;
      $display("FAIL b2b_busy: got %0d/%0d want 200/1", busy_n, falls);
    end
    tests++;
    if (done_n != 5) begin
      fails++;
      $display("FAIL b2b_done: got %0d want 5", done_n);
    end
    drain();
  endtask

  task automatic test_loopback();
    int rx0;
    int err0;
    logic [7:0] pat [3];
    pat[0] = 8'h00;
    pat[1] = 8'hFF;
    pat[2] = 8'h55;
    rx0 = rx_done_cnt;
    err0 = rx_err_cnt;
    for (int k = 0; k < 3; k++) begin
      tx_data1 = pat[k];
      tx_start1 = 1'b1;
      sb.push_back(pat[k]);
      tick();
    end
    tx_start1 = 1'b0;
    drain();
    tests++;
    if (rx_done_cnt - rx0 != 3 || rx_err_cnt != err0) begin
      fails++;
      $display("FAIL loop_count: got %0d err %0d want 3 err 0",
               rx_done_cnt - rx0, rx_err_cnt - err0);
    end
  endtask

  task automatic test_stop2();
    int   busy_n = 0;
    int   done_n = 0;
    int   done_at = 0;
    logic e;
    rx_sel = 1'b1;
    tx_data2 = 8'h3C;
    tx_start2 = 1'b1;
    sb.push_back(8'h3C);
    tick();
    tx_start2 = 1'b0;
    for (int k = 1; k <= 11 * DIV; k++) begin
      tick();
      e = frame_bit(8'h3C, (k - 1) / DIV);
      tests++;
      if (txd2 !== e) begin
        fails++;
        $display("FAIL stop2_txd clk %0d: got %b want %b", k, txd2, e);
      end
      if (tx_busy2 === 1'b1) busy_n++;
      if (tx_done2 === 1'b1) begin
        done_n++;
        done_at = k;
      end
    end
    tick();
    tests++;
    if (busy_n != 44 || tx_busy2 !== 1'b0) begin
      fails++;
      $display("FAIL stop2_busy: got %0d/%b want 44/0", busy_n, tx_busy2);
    end
    tests++;
    if (done_n != 1 || done_at != 44) begin
      fails++;
      $display("FAIL stop2_done: got %0d@%0d want 1@44", done_n, done_at);
    end
    drain();
    rx_sel = 1'b0;
  endtask

  task automatic test_push_pop_same_edge();
    logic exp_rdy;
    for (int k = 1; k <= 3; k++) begin
      tx_data1 = 8'hC0 + 8'(k);
      tx_start1 = 1'b1;
      sb.push_back(8'hC0 + 8'(k));
      tick();
    end
    tx_start1 = 1'b0;
    repeat (38) tick();
    tests++;
    if (tx_done1 !== 1'b1) begin
      fails++;
      $display("FAIL pp_done_align: got %b want 1", tx_done1);
    end
    for (int k = 4; k <= 7; k++) begin
      tx_data1 = 8'hC0 + 8'(k);
      tx_start1 = 1'b1;
      if (k <= 6) sb.push_back(8'hC0 + 8'(k));
      tick();
      exp_rdy = (k < 6);
      tests++;
      if (tx_ready1 !== exp_rdy) begin
        fails++;
        $display("FAIL pp_ready byte %0d: got %b want %b", k, tx_ready1, exp_rdy);
      end
    end
    tx_start1 = 1'b0;
    drain();
  endtask

  task automatic test_midframe_reset();
    int done_n = 0;
    int busy_n = 0;
    int low_n = 0;
    rx_en = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tx_data1 = 8'h11 * 8'(k);
      tx_start1 = 1'b1;
      tick();
    end
    tx_start1 = 1'b0;
    repeat (13) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (txd1 !== 1'b1 || tx_busy1 !== 1'b0 || tx_ready1 !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid: got txd %b busy %b ready %b want 1 0 1",
               txd1, tx_busy1, tx_ready1);
    end
    for (int k = 0; k < 200; k++) begin
      tick();
      if (tx_done1 === 1'b1) done_n++;
      if (tx_busy1 === 1'b1) busy_n++;
      if (txd1 !== 1'b1) low_n++;
    end
    tests++;
    if (done_n != 0 || busy_n != 0 || low_n != 0) begin
      fails++;
      $display("FAIL rst_quiet: got done %0d busy %0d low %0d want 0 0 0",
               done_n, busy_n, low_n);
    end
    rx_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_loopback();
    test_stop2();
    test_push_pop_same_edge();
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered UART transmitter, the transmit-side counterpart of `uart_rx`. It accepts bytes from on-chip logic through a write-strobe/ready handshake and queues them in a small FIFO. It serializes each byte onto `txd` as 8N1 or 8N2 (LSB first, no parity) with back-to-back frames and no idle gap. It sits next to `uart_rx` on the same clock domain and drives the pad directly.

## Interface
- `CLK_HZ`, default 200_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate. `DIV = CLK_HZ / BAUD` (integer division). Required range is 2 ≤ DIV ≤ 65535.
- `FIFO_DEPTH`, default 4: queue entries. Must be a power of 2 and ≥ 2.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `clk` input, 1 bit: single clock. All logic is on the rising edge.
- `rst` input, 1 bit: reset is synchronous and active-high.
- `tx_data` input, 8 bits: byte to send. Sampled when `tx_start && tx_ready`.
- `tx_start` input, 1 bit: write strobe. May be held high for consecutive writes.
- `tx_ready` output, 1 bit: FIFO not full. Equal to `~full`, taken from the registered count.
- `tx_busy` output, 1 bit: a frame is on the line.
- `tx_done` output, 1 bit: one-cycle strobe on the last clock of a frame's final stop bit.
- `txd` output, 1 bit: serial line, registered, idles high.

## Operation
- Reset values: `txd`=1, `tx_busy`=0, `tx_done`=0, FIFO count=0, `tx_ready`=1, state=IDLE.
- A write is accepted at any rising edge where `tx_start && tx_ready`. The byte is pushed into the FIFO.
- Writes while `tx_ready`=0 are dropped silently. This holds even if a pop occurs on the same edge, because readiness uses the registered count.
- A push and a pop on the same edge leave the count unchanged.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: `txd`=1. If the FIFO is non-empty, pop the head into the shift register, load the bit counter with DIV−1, and go to START.
  - START: `txd`=0 for DIV clocks, then go to DATA with bit index 0.
  - DATA: `txd` = shift register bit[0]. Every DIV clocks, shift right and increment the 3-bit index. After index 7 completes, go to STOP.
  - STOP: `txd`=1 for STOP_BITS×DIV clocks. On the final clock, assert `tx_done`. If the FIFO is non-empty, pop and go to START on the next edge (no idle clock). Otherwise go to IDLE.
- The baud counter is 16 bits and counts down from DIV−1 to 0. Reaching 0 ends the bit period. It does not run in IDLE.
- `tx_busy` is high in START, DATA and STOP.
- If `rst` is asserted mid-frame, the next edge forces `txd`=1, flushes the FIFO, and returns to IDLE. The partial frame is abandoned and `tx_done` is not pulsed.

## Timing
- Let E0 be the acceptance edge with the FSM idle and FIFO empty. The pop happens at E1. `txd` falls and `tx_busy` rises after E1.
- Each bit lasts exactly DIV clocks. A frame lasts (9+STOP_BITS)×DIV clocks.
- `tx_done` is high during the last clock of the frame, i.e. the clock preceding edge E1+(9+STOP_BITS)×DIV.
- For back-to-back frames, the next start bit begins on the edge immediately after the final stop clock.
- `tx_busy` stays high across queued frames and falls at the same edge the FSM enters IDLE.
- Capacity is FIFO_DEPTH queued bytes plus 1 in the shift register.

## Structure
- Package `uart_pkg` holds:
  - the state enum `uart_tx_state_t` (IDLE/START/DATA/STOP);
  - the function `baud_div(CLK_HZ, BAUD)` returning a 16-bit value;
  - the constant `UART_DATA_BITS = 8`.
- Sub-module `uart_tx_fifo`: synchronous FIFO with active-high sync reset, parameters WIDTH/DEPTH, ports push/pop/din/dout/full/empty. It has a registered count, and `dout` always shows the head entry.
- Elaboration-time assertions check the DIV range, that FIFO_DEPTH is a power of 2, and that STOP_BITS ∈ {1,2}.

## Test plan
All scenarios use CLK_HZ=1_000_000 and BAUD=250_000, so DIV=4.
- Single byte 0xA5, STOP_BITS=1:
  - `txd` after E1 is 0,1,0,1,0,0,1,0,1,1, each held 4 clocks.
  - `tx_done` is a single pulse in clock 40 after E1.
  - `tx_busy` is high for 40 clocks.
- `tx_start` held high with data 0x01..0x06 on 6 consecutive edges from idle, FIFO_DEPTH=4:
  - 0x01–0x05 are accepted and `tx_ready` is 0 from the 5th edge.
  - 0x06 is dropped.
  - Five frames go out back-to-back with no idle clock between frames.
- Loopback to `uart_rx` with the same parameters, sending 0x00, 0xFF, 0x55 back-to-back: `rx_data` sequence is 0x00, 0xFF, 0x55, `rx_done` pulses 3 times, and `rx_err` is never high.
- STOP_BITS=2 with 0x3C: frame is 44 clocks, with the last 8 clocks high. `tx_done` is in clock 44.
- `rst` asserted for 1 clock at clock 15 of a frame with 2 bytes queued:
  - `txd`=1, `tx_busy`=0, `tx_ready`=1 after that edge.
  - No further frames and no `tx_done`.
- Push and pop on the same edge at count=2 (write during a STOP→START transition): count stays 2 and byte order is preserved.
